sqrt_output_wrapper_dp: RTL

//  Back end of the sqrt datapath. Captures the operand's type, exponent and flags at start.

---
 rtl/sqrt_output_wrapper_dp_if.sv | 30 +++
 rtl/sqrt_output_wrapper_dp.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sqrt_output_wrapper_dp_if.sv
// Handshake and data bundle between the sqrt core/front end (master) and the output wrapper (slave).
interface sqrt_output_wrapper_dp_if #(
  parameter int EXP_SIZE  = 11,
  parameter int ROOT_SIZE = 55,
  parameter int RES_SIZE  = 64
);
  logic                 start;
  logic                 in_type;
  logic [EXP_SIZE-1:0]  in_exp;
  logic [2:0]           in_flags;
  logic                 root_valid;
  logic [ROOT_SIZE-1:0] root;
  logic                 rem_nz;
  logic                 out_ack;
  logic                 ready;
  logic                 out_valid;
  logic [RES_SIZE-1:0]  result;
  logic                 invalid;
  logic                 inexact;

  modport master (
    output start, in_type, in_exp, in_flags, root_valid, root, rem_nz, out_ack,
    input  ready, out_valid, result, invalid, inexact
  );

  modport slave (
    input  start, in_type, in_exp, in_flags, root_valid, root, rem_nz, out_ack,
    output ready, out_valid, result, invalid, inexact
  );
endinterface

// File: rtl/sqrt_output_wrapper_dp.sv
// Sqrt back end: rounds the core's root to nearest-even, halves the exponent,
// substitutes IEEE specials and holds the packed word under a valid/ack handshake.
module sqrt_output_wrapper_dp #(
  parameter int EXP_SIZE  = 11,
  parameter int ROOT_SIZE = 55,
  parameter int RES_SIZE  = 64,
  parameter int DBL_BIAS  = 1023,
  parameter int SGL_BIAS  = 127
) (
  input logic clk,
  input logic rst,
  sqrt_output_wrapper_dp_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_ROOT, ROUND, HOLD} state_t;

  state_t               r_state, w_state_next;
  logic                 r_type;
  logic [EXP_SIZE-1:0]  r_exp;
  logic [ROOT_SIZE-1:0] r_root;
  logic                 r_rem_nz;
  logic [RES_SIZE-1:0]  r_result;
  logic                 r_invalid;
  logic                 r_inexact;
  logic                 w_ready;
  logic                 w_out_valid;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.start) w_state_next = (bus.in_flags == 3'b100) ? WAIT_ROOT : HOLD;
      end
      WAIT_ROOT: if (bus.root_valid) w_state_next = ROUND;
      ROUND:     w_state_next = HOLD;
      HOLD: begin
        w_out_valid = 1'b1;
        if (bus.out_ack) w_state_next = IDLE;
      end
      default:   w_state_next = IDLE;
    endcase
  end

  // Special results are decoded straight from the inputs so they are ready one cycle after start.
  logic [RES_SIZE-1:0] w_spec_res;
  logic                w_spec_inv;
  logic [RES_SIZE-1:0] w_qnan;

  always_comb begin
    w_qnan     = bus.in_type ? RES_SIZE'(64'h7FF8_0000_0000_0000) : RES_SIZE'(64'h0000_0000_7FC0_0000);
    w_spec_res = w_qnan;
    w_spec_inv = 1'b0;
    case (bus.in_flags)
      3'b000:  w_spec_res = '0;
      3'b010:  w_spec_res = bus.in_type ? RES_SIZE'(64'h7FF0_0000_0000_0000)
                                        : RES_SIZE'(64'h0000_0000_7F80_0000);
      3'b111:  w_spec_inv = 1'b1;
      default: w_spec_res = w_qnan;
    endcase
  end

  // Floor of (biased exp + bias) / 2 absorbs the odd/even unbiased exponent.
  logic [11:0] w_exp_sum;
  logic [10:0] w_half_exp;

  assign w_exp_sum  = r_type ? (12'(r_exp) + 12'(DBL_BIAS)) : (12'(r_exp[7:0]) + 12'(SGL_BIAS));
  assign w_half_exp = 11'(w_exp_sum >> 1);

  logic [52:0] w_d_mant;
  logic        w_d_guard, w_d_sticky, w_d_inc;
  logic [53:0] w_d_sum;
  logic [10:0] w_d_exp;
  logic [63:0] w_d_word;

  assign w_d_mant   = r_root[54:2];
  assign w_d_guard  = r_root[1];
  assign w_d_sticky = r_root[0] | r_rem_nz;
  assign w_d_inc    = w_d_guard & (w_d_sticky | w_d_mant[0]);
  assign w_d_sum    = {1'b0, w_d_mant} + 54'(w_d_inc);
  assign w_d_exp    = w_half_exp + 11'(w_d_sum[53]);
  assign w_d_word   = {1'b0, w_d_exp, 52'(w_d_sum)};

  logic [23:0] w_s_mant;
  logic        w_s_guard, w_s_sticky, w_s_inc;
  logic [24:0] w_s_sum;
  logic [7:0]  w_s_exp;
  logic [63:0] w_s_word;

  assign w_s_mant   = r_root[54:31];
  assign w_s_guard  = r_root[30];
  assign w_s_sticky = (|r_root[29:0]) | r_rem_nz;
  assign w_s_inc    = w_s_guard & (w_s_sticky | w_s_mant[0]);
  assign w_s_sum    = {1'b0, w_s_mant} + 25'(w_s_inc);
  // A carry out of the mantissa leaves the fraction at zero (1.0) and bumps the exponent.
  assign w_s_exp    = w_half_exp[7:0] + 8'(w_s_sum[24]);
  assign w_s_word   = {32'b0, 1'b0, w_s_exp, 23'(w_s_sum)};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_type    <= 1'b0;
      r_exp     <= '0;
      r_root    <= '0;
      r_rem_nz  <= 1'b0;
      r_result  <= '0;
      r_invalid <= 1'b0;
      r_inexact <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_type    <= bus.in_type;
          r_exp     <= bus.in_exp;
          r_result  <= w_spec_res;
          r_invalid <= w_spec_inv;
          r_inexact <= 1'b0;
        end
        WAIT_ROOT: if (bus.root_valid) begin
          r_root   <= bus.root;
          r_rem_nz <= bus.rem_nz;
        end
        ROUND: begin
          r_result  <= r_type ? RES_SIZE'(w_d_word) : RES_SIZE'(w_s_word);
          r_invalid <= 1'b0;
          r_inexact <= r_type ? (w_d_guard | w_d_sticky) : (w_s_guard | w_s_sticky);
        end
        default: ;
      endcase
    end
  end

  assign bus.ready     = w_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.result    = r_result;
  assign bus.invalid   = r_invalid;
  assign bus.inexact   = r_inexact;

endmodule
